// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte header (0..DATA_BYTE_WD) from the front of each AXI-Stream packet, header out right-aligned on a sideband.
// Latency: 1 cycle from input acceptance to registered payload/header outputs; a K>N last beat costs one extra FLUSH beat.
// Backpressure: ready_in drops while the needed output slot (payload, plus header on the first beat) is occupied; optional STRIP_BYTE_CNT_EN adds byte_cnt.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
`ifdef STRIP_BYTE_CNT_EN
   ,
   parameter int CNT_WD       = 16
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   input  logic                    valid_strip,
   input  logic [LEN_WD-1:0]       strip_len,
   output logic                    ready_strip,
   output logic                    valid_header,
   output logic [DATA_WD-1:0]      header_out,
   output logic [DATA_BYTE_WD-1:0] keep_header,
   input  logic                    ready_header,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out
`ifdef STRIP_BYTE_CNT_EN
   ,
   output logic [CNT_WD-1:0]       byte_cnt
`endif
);

   localparam logic [LEN_WD-1:0] B_L = LEN_WD'(DATA_BYTE_WD);
   localparam logic [LEN_WD:0]   B_S = (LEN_WD+1)'(DATA_BYTE_WD);

   typedef enum logic [1:0] {IDLE, HEAD, BODY, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [LEN_WD-1:0]       n_q;      // clamped header length of the current packet
   logic [LEN_WD-1:0]       r_q;      // residual byte count carried between beats
   logic [DATA_WD-1:0]      res_q;    // residual bytes, MSB-aligned, low bytes zero
   logic [DATA_WD-1:0]      din_m;    // input data with disabled bytes forced to zero
   logic [LEN_WD-1:0]       k_in, nh, pay, r_d;
   logic [LEN_WD:0]         sum;
   logic                    out_free, hdr_free;
   logic                    ld_out, ld_hdr, ld_res, out_last_d;
   logic [DATA_WD-1:0]      out_dat_d, hdr_dat_d, res_d;
   logic [DATA_BYTE_WD-1:0] out_keep_d, hdr_keep_d;

   function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [LEN_WD:0] c);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++)
         m[DATA_BYTE_WD-1-i] = ((LEN_WD+1)'(i) < c);
      return m;
   endfunction

   function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [LEN_WD:0] c);
      logic [DATA_BYTE_WD-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++)
         m[i] = ((LEN_WD+1)'(i) < c);
      return m;
   endfunction

   // Mask the input bytes and count valid bytes (keep is contiguous from MSB).
   always_comb begin
      din_m = '0;
      k_in  = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         din_m[i*8 +: 8] = data_in[i*8 +: 8] & {8{keep_in[i]}};
         k_in            = k_in + {{(LEN_WD-1){1'b0}}, keep_in[i]};
      end
   end

   assign out_free = !valid_out || ready_out;
   assign hdr_free = !valid_header || ready_header;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, handshakes and the values to load into the output/residual registers.
   always_comb begin
      state_d     = state_q;
      ready_in    = 1'b0;
      ready_strip = 1'b0;
      ld_out      = 1'b0;
      ld_hdr      = 1'b0;
      ld_res      = 1'b0;
      out_dat_d   = '0;
      out_keep_d  = '0;
      out_last_d  = 1'b0;
      hdr_dat_d   = '0;
      hdr_keep_d  = '0;
      res_d       = '0;
      r_d         = r_q;
      sum         = {1'b0, r_q} + {1'b0, k_in};
      nh          = (last_in && (k_in < n_q)) ? k_in : n_q;
      pay         = (k_in > n_q) ? (k_in - n_q) : '0;
      case (state_q)
         IDLE: begin
            if (valid_strip) state_d = HEAD;
         end
         HEAD: begin
            ready_in = hdr_free && out_free;
            if (valid_in && ready_in) begin
               ready_strip = 1'b1;
               ld_hdr      = (nh != '0);
               hdr_dat_d   = din_m >> {B_L - nh, 3'b000};
               hdr_keep_d  = low_mask({1'b0, nh});
               if (last_in) begin
                  state_d = IDLE;
                  if (pay != '0) begin
                     ld_out     = 1'b1;
                     out_dat_d  = din_m << {n_q, 3'b000};
                     out_keep_d = top_mask({1'b0, pay});
                     out_last_d = 1'b1;
                  end
               end else begin
                  state_d = BODY;
                  ld_res  = 1'b1;
                  if (n_q == '0) begin
                     // No header: the first beat goes straight out, nothing carried.
                     ld_out     = 1'b1;
                     out_dat_d  = din_m;
                     out_keep_d = '1;
                     r_d        = '0;
                  end else begin
                     r_d   = B_L - n_q;
                     res_d = din_m << {n_q, 3'b000};
                  end
               end
            end
         end
         BODY: begin
            ready_in = out_free;
            if (valid_in && ready_in) begin
               ld_out    = 1'b1;
               ld_res    = 1'b1;
               out_dat_d = res_q | (din_m >> {r_q, 3'b000});
               res_d     = din_m << {B_L - r_q, 3'b000};
               if (last_in) begin
                  if (sum > B_S) begin
                     out_keep_d = '1;
                     r_d        = sum[LEN_WD-1:0] - B_L;
                     state_d    = FLUSH;
                  end else begin
                     out_keep_d = top_mask(sum);
                     out_last_d = 1'b1;
                     r_d        = '0;
                     res_d      = '0;
                     state_d    = IDLE;
                  end
               end else begin
                  out_keep_d = '1;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               ld_out     = 1'b1;
               out_dat_d  = res_q;
               out_keep_d = top_mask({1'b0, r_q});
               out_last_d = 1'b1;
               ld_res     = 1'b1;
               r_d        = '0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, residual and latched strip length.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q          <= '0;
         r_q          <= '0;
         res_q        <= '0;
         valid_out    <= 1'b0;
         data_out     <= '0;
         keep_out     <= '0;
         last_out     <= 1'b0;
         valid_header <= 1'b0;
         header_out   <= '0;
         keep_header  <= '0;
      end else begin
         if (state_q == IDLE && valid_strip)
            n_q <= (strip_len > B_L) ? B_L : strip_len;
         if (ld_res) begin
            res_q <= res_d;
            r_q   <= r_d;
         end
         if (ld_out) begin
            valid_out <= 1'b1;
            data_out  <= out_dat_d;
            keep_out  <= out_keep_d;
            last_out  <= out_last_d;
         end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
         end
         if (ld_hdr) begin
            valid_header <= 1'b1;
            header_out   <= hdr_dat_d;
            keep_header  <= hdr_keep_d;
         end else if (valid_header && ready_header) begin
            valid_header <= 1'b0;
         end
      end
   end

`ifdef STRIP_BYTE_CNT_EN
   logic [CNT_WD-1:0] cnt_q;
   logic [CNT_WD:0]   cnt_sum;

   assign cnt_sum  = {1'b0, cnt_q} + (CNT_WD+1)'(k_in);
   assign byte_cnt = cnt_q;

   // Payload byte count: restarts on the first beat, saturates on later beats.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (state_q == HEAD && valid_in && ready_in)
         cnt_q <= CNT_WD'(pay);
      else if (state_q == BODY && valid_in && ready_in)
         cnt_q <= cnt_sum[CNT_WD] ? '1 : cnt_sum[CNT_WD-1:0];
   end
`endif

endmodule
